// File: rtl/hist_eq_lut_builder.sv
// Histogram-equalisation LUT builder: accumulates a 256-bin histogram over one
// frame, then scans the CDF and streams one equalised entry per LUT address.
module hist_eq_lut_builder #(
  parameter int LOG2_PIXELS = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pix_valid,
  input  logic [7:0] pix_data,
  output logic       busy,
  output logic       lut_we,
  output logic [7:0] lut_addr,
  output logic [7:0] lut_data,
  output logic       done
);

  localparam int CNT_W  = LOG2_PIXELS + 1;
  localparam int PROD_W = CNT_W + 8;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'((1 << LOG2_PIXELS) - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SCAN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_hist [256];
  logic [CNT_W-1:0]   r_pix_cnt;
  logic [CNT_W-1:0]   r_cdf;
  logic [7:0]         r_idx;
  logic               r_lut_we;
  logic [7:0]         r_lut_addr;
  logic [7:0]         r_lut_data;
  logic               r_done;

  logic               w_accept;
  logic               w_last_pix;
  logic               w_clear;
  logic [CNT_W-1:0]   w_cdf_next;
  logic [PROD_W-1:0]  w_prod;
  logic [PROD_W-1:0]  w_scaled;
  logic [7:0]         w_lut_val;

  assign w_accept   = (r_state == S_ACCUM) && pix_valid;
  assign w_last_pix = w_accept && (r_pix_cnt == LAST_PIX);
  assign w_clear    = (r_state == S_IDLE) && start;

  // A full bin plus the running CDF never exceeds N, so CNT_W bits suffice.
  assign w_cdf_next = r_cdf + r_hist[r_idx];
  assign w_prod     = PROD_W'(w_cdf_next) * PROD_W'(255);
  assign w_scaled   = w_prod >> LOG2_PIXELS;
  assign w_lut_val  = (w_scaled > PROD_W'(255)) ? 8'hFF : w_scaled[7:0];

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)       w_next = S_ACCUM;
      S_ACCUM: if (w_last_pix)  w_next = S_SCAN;
      S_SCAN:  if (r_idx == 8'hFF) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: bins are a flop array with async reset, so the clear-on-reset costs no extra cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) r_hist[i] <= '0;
    end else if (w_clear) begin
      for (int i = 0; i < 256; i++) r_hist[i] <= '0;
    end else if (w_accept) begin
      r_hist[pix_data] <= r_hist[pix_data] + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt  <= '0;
      r_cdf      <= '0;
      r_idx      <= '0;
      r_lut_we   <= 1'b0;
      r_lut_addr <= '0;
      r_lut_data <= '0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_pix_cnt <= '0;
            r_cdf     <= '0;
          end
        end
        S_ACCUM: begin
          if (w_accept)   r_pix_cnt <= r_pix_cnt + ONE;
          if (w_last_pix) r_idx     <= '0;
        end
        S_SCAN: begin
          r_cdf      <= w_cdf_next;
          r_lut_we   <= 1'b1;
          r_lut_addr <= r_idx;
          r_lut_data <= w_lut_val;
          r_idx      <= r_idx + 8'd1;
        end
        S_DONE: begin
          r_lut_we <= 1'b0;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == S_ACCUM) || (r_state == S_SCAN);
  assign lut_we   = r_lut_we;
  assign lut_addr = r_lut_addr;
  assign lut_data = r_lut_data;
  assign done     = r_done;

endmodule

// File: doc/hist_eq_lut_builder.md
Name: hist_eq_lut_builder

Overview:
Upstream stage of the 8-bit pixel-mapping LUT. It accumulates a 256-bin histogram over one frame of 2^LOG2_PIXELS pixels. It then scans the cumulative distribution and emits one histogram-equalisation entry per LUT address as a write stream (we/addr/data). The LUT stage consumes this stream in place of its static initial contents, which makes the pixel mapping adaptive per frame.

Parameters:
LOG2_PIXELS, 16, log2 of pixels per frame (N = 2^LOG2_PIXELS); range 2..20
CNT_W, LOG2_PIXELS+1, width of each histogram bin and of the CDF accumulator; derived, do not override

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; clears histogram and begins a frame; honoured in IDLE only
pix_valid  input  1  pix_data valid this cycle
pix_data  input  8  pixel intensity
busy  output  1  high in ACCUM and SCAN
lut_we  output  1  LUT write enable, registered
lut_addr  output  8  LUT write address, registered
lut_data  output  8  LUT write data, registered
done  output  1  one-cycle pulse after the last LUT write

Behaviour:
- Reset (rst_n low, async): state=IDLE. busy, lut_we, lut_addr, lut_data and done are 0. Pixel counter, scan index and CDF are 0. Bins are 0.
- Storage: flop array of 256 bins, CNT_W bits each. A single bin can reach N with no overflow.
- States: IDLE, ACCUM, SCAN, DONE.
- IDLE: on start, all bins, pixel counter and CDF are cleared at that edge -> ACCUM. pix_valid is ignored.
- ACCUM:
  - Each cycle with pix_valid=1: hist[pix_data]+=1 and pix_cnt+=1. This is a single-cycle update, so back-to-back identical pixels count correctly.
  - Gaps (pix_valid=0) hold all state.
  - When the N-th pixel is accepted: -> SCAN, idx=0 at that edge.
- SCAN, 256 cycles, idx = 0..255. At each edge:
  - cdf <= cdf + hist[idx]
  - lut_we <= 1
  - lut_addr <= idx
  - lut_data <= min(255, ((cdf + hist[idx]) * 255) >> LOG2_PIXELS), floor rounding; intermediate width CNT_W+8
  - idx <= idx+1
  - At idx==255: -> DONE.
  - Write k (addr k) is visible in the cycle after the k-th SCAN edge, so exactly 256 consecutive lut_we cycles occur, addresses ascending 0..255 with no gaps.
- DONE: at the edge leaving SCAN's last cycle, lut_we<=0 and done<=1. Next edge: done<=0 -> IDLE. done is high exactly one cycle, the cycle after the final write cycle.
- Entry at addr 255 is always 255 (cdf=N). Bins below the lowest occurring intensity map to 0.
- start while busy or in DONE: ignored. No restart, no effect on counts.
- pix_valid outside ACCUM: ignored. Bins do not change.
- lut_addr/lut_data hold their last values when lut_we=0. Consumers qualify them with lut_we.
- Reset mid-ACCUM or mid-SCAN: immediate return to reset values. lut_we drops asynchronously, and the partial table is abandoned. The next start after rst_n release runs a clean frame.
- Latency: start -> first lut_we = N + 1 cycles with no gaps (N accept cycles, then 1 register cycle). The full table completes N + 256 cycles after the first accepted pixel.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle -> all outputs 0 asynchronously. After release, state is IDLE and busy=0.
2. LOG2_PIXELS=8, start, pixels 0..255 once each, back-to-back -> 256 writes. addr0=0, addr127=127, addr128=128, addr255=255 (each = floor((i+1)*255/256)). done one cycle after the last write.
3. LOG2_PIXELS=4, 16 pixels all =100 with random pix_valid gaps -> busy high throughout. Writes: addr 0..99 data 0, addr 100..255 data 255. done pulses once.
4. LOG2_PIXELS=2, pixels 10,10,200,50 -> addr 0..9 data 0; 10..49 data 127; 50..199 data 191; 200..255 data 255.
5. start pulses and pix_valid pulses with random data during SCAN and DONE -> table identical to an undisturbed run. No second frame starts. Extra pixels are not counted.
6. rst_n low at SCAN idx=60 -> lut_we=0 immediately. After release, a new frame per scenario 4 gives the exact scenario-4 table with no residue from the aborted frame.
